cache_miss_sequencer: RTL and testbench
=======================================

Name: cache_miss_sequencer

Overview:
- Per-cache miss handler between one cache controller and one connection of the shared cache-memory bus arbiter.
- Accepts a line miss, with an optional dirty victim, from the cache.
- Issues a line load on the bus command interface and returns the refill line to the cache.
- Then issues the victim writeback as a line store (fill-before-writeback, single-entry victim buffer).
- One instance per bus connection.

Parameters:
DATA_WIDTH, 64, bus beat width in bits
ADDR_WIDTH, 64, byte address width
CHUNKS_LOG, 3, log2 beats per line; LINE_W = DATA_WIDTH*2**CHUNKS_LOG (512); OFF_W = log2(LINE_W/8) (6)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
miss_valid  in  1  cache presents a miss
miss_ready  out  1  sequencer accepts the miss this cycle
miss_addr  in  ADDR_WIDTH  missing byte address; low OFF_W bits ignored
miss_dirty  in  1  victim line must be written back
victim_addr  in  ADDR_WIDTH  victim byte address; low OFF_W bits ignored
victim_data  in  LINE_W  victim line contents
fill_valid  out  1  refill line valid; one-cycle pulse
fill_addr  out  ADDR_WIDTH  line-aligned refill address
fill_data  out  LINE_W  refill line
command_valid  out  1  request to the bus arbiter
command_store  out  1  1 = line store, 0 = line load
command_addr  out  ADDR_WIDTH  line-aligned request address; low OFF_W bits always 0
data_in  out  LINE_W  store data to the arbiter
bus_ready  in  1  arbiter accepted the request (handshake with command_valid)
bus_valid  in  1  arbiter load response valid
data_out  in  LINE_W  arbiter load response line
command_ready  out  1  sequencer accepts the load response
miss_count  out  32  accepted misses, wraps
wb_count  out  32  completed writebacks, wraps

Behaviour:
- States: IDLE, LD_REQ, LD_WAIT, FILL, WB_REQ.
- Reset values:
  - state = IDLE
  - all valid/ready outputs 0
  - victim buffer invalid
  - fill_addr, fill_data, command_addr, data_in = 0
  - counters = 0
- IDLE:
  - miss_ready = 1 only in IDLE.
  - On miss_valid & miss_ready:
    - latch line address = {miss_addr[ADDR_WIDTH-1:OFF_W], OFF_W'0}
    - if miss_dirty, latch victim line address and victim_data into the buffer and mark it valid
    - miss_count += 1
    - go to LD_REQ
- LD_REQ:
  - command_valid = 1, command_store = 0, command_addr = latched line address.
  - Hold all request outputs stable until bus_ready; then go to LD_WAIT.
  - command_valid must not drop before the handshake.
- LD_WAIT:
  - command_ready = 1.
  - On bus_valid, capture data_out into fill_data and go to FILL.
  - bus_valid arriving while in LD_REQ is ignored; the response is never accepted before request acceptance.
- FILL:
  - fill_valid = 1 for exactly one cycle; fill_addr = latched line address.
  - The cache must accept the fill unconditionally.
  - Next state: WB_REQ if the victim buffer is valid, else IDLE.
- WB_REQ:
  - command_valid = 1, command_store = 1, command_addr = buffered victim line address, data_in = buffered line.
  - The writeback completes on the bus_ready handshake:
    - buffer becomes invalid
    - wb_count += 1
    - go to IDLE
- Latency, ideal (bus_ready and bus_valid asserted the first cycle they are sampled):
  - miss accepted at cycle 0
  - load handshake at cycle 1
  - response at cycle 2
  - fill_valid at cycle 3
  - writeback handshake at cycle 4
  - miss_ready high again at cycle 5 (cycle 4 if clean)
- New misses are not accepted until any pending writeback completes. This removes any need to forward the victim line when the next miss targets the victim address.
- Victim and miss addresses equal (line granularity), dirty: legal. The fill is still delivered first, then the stale victim is written. The cache is responsible for not presenting this case.
- Outputs are registered, or decoded from state only. No combinational path from bus inputs to bus outputs.
- Reset mid-operation:
  - return to IDLE next cycle
  - drop the in-flight request and victim buffer
  - no fill_valid is emitted
  - counters are cleared
- Counters wrap from 0xFFFFFFFF to 0.

Test Plan:
- Clean miss at 0x1000_0047, arbiter bus_ready and bus_valid immediate, data_out = 0xA5 pattern:
  - command_addr = 0x1000_0040, command_store = 0
  - fill_valid pulses once at cycle 3 with fill_addr = 0x1000_0040 and fill_data = pattern
  - miss_count = 1, wb_count = 0
- Dirty miss (miss 0x2000_0000, victim 0x3000_0010, victim_data = 0x55 pattern):
  - load to 0x2000_0000, then fill, then store to 0x3000_0000 with data_in = 0x55 pattern
  - wb_count = 1
  - miss_ready is low from acceptance through the writeback handshake
- Back-pressure: bus_ready held low 10 cycles in LD_REQ and 7 in WB_REQ:
  - command_valid, command_addr and data_in stay stable throughout
  - each handshake happens exactly once
- Spurious bus_valid during LD_REQ before bus_ready:
  - ignored; fill uses data_out from the first bus_valid in LD_WAIT
- Reset asserted in LD_WAIT, and separately in WB_REQ:
  - next cycle: state IDLE, command_valid = 0, miss_ready = 1, counters = 0
  - no fill_valid pulse afterwards
- 4 back-to-back dirty misses with miss_valid held high:
  - exactly 4 loads, 4 fills, 4 stores, strictly ordered load→fill→store per miss
  - miss_count = 4, wb_count = 4

Source files
------------

// File: rtl/cache_miss_sequencer.sv
// Per-cache miss handler: loads the missing line over the shared bus, returns it
// to the cache, then writes back the buffered dirty victim before taking a new miss.
module cache_miss_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int CHUNKS_LOG = 3,
    localparam int LINE_W = DATA_WIDTH * (2 ** CHUNKS_LOG),
    localparam int OFF_W = $clog2(LINE_W / 8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  miss_dirty_i,
    input  logic [ADDR_WIDTH-1:0] victim_addr_i,
    input  logic [LINE_W-1:0]     victim_data_i,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [LINE_W-1:0]     fill_data_o,
    output logic                  command_valid_o,
    output logic                  command_store_o,
    output logic [ADDR_WIDTH-1:0] command_addr_o,
    output logic [LINE_W-1:0]     data_in_o,
    input  logic                  bus_ready_i,
    input  logic                  bus_valid_i,
    input  logic [LINE_W-1:0]     data_out_i,
    output logic                  command_ready_o,
    output logic [31:0]           miss_count_o,
    output logic [31:0]           wb_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        FILL,
        WB_REQ
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] lineAddr_q, lineAddr_d;
    logic [ADDR_WIDTH-1:0] victimAddr_q, victimAddr_d;
    logic [LINE_W-1:0]     victimData_q, victimData_d;
    logic                  victimValid_q, victimValid_d;
    logic [LINE_W-1:0]     fillData_q, fillData_d;
    logic [31:0]           missCount_q, missCount_d;
    logic [31:0]           wbCount_q, wbCount_d;

    logic [ADDR_WIDTH-1:0] missLine;
    logic [ADDR_WIDTH-1:0] victimLine;

    assign missLine   = miss_addr_i & LINE_MASK;
    assign victimLine = victim_addr_i & LINE_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lineAddr_q    <= '0;
            victimAddr_q  <= '0;
            victimData_q  <= '0;
            victimValid_q <= 1'b0;
            fillData_q    <= '0;
            missCount_q   <= '0;
            wbCount_q     <= '0;
        end else begin
            state_q       <= state_d;
            lineAddr_q    <= lineAddr_d;
            victimAddr_q  <= victimAddr_d;
            victimData_q  <= victimData_d;
            victimValid_q <= victimValid_d;
            fillData_q    <= fillData_d;
            missCount_q   <= missCount_d;
            wbCount_q     <= wbCount_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lineAddr_d    = lineAddr_q;
        victimAddr_d  = victimAddr_q;
        victimData_d  = victimData_q;
        victimValid_d = victimValid_q;
        fillData_d    = fillData_q;
        missCount_d   = missCount_q;
        wbCount_d     = wbCount_q;

        case (state_q)
            IDLE: begin
                if (miss_valid_i) begin
                    lineAddr_d  = missLine;
                    missCount_d = missCount_q + 32'd1;
                    state_d     = LD_REQ;
                    if (miss_dirty_i) begin
                        victimAddr_d  = victimLine;
                        victimData_d  = victim_data_i;
                        victimValid_d = 1'b1;
                    end
                end
            end
            LD_REQ: begin
                if (bus_ready_i) begin
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (bus_valid_i) begin
                    fillData_d = data_out_i;
                    state_d    = FILL;
                end
            end
            FILL: begin
                state_d = victimValid_q ? WB_REQ : IDLE;
            end
            WB_REQ: begin
                if (bus_ready_i) begin
                    victimValid_d = 1'b0;
                    wbCount_d     = wbCount_q + 32'd1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output is a register or a pure decode of state, so no bus input reaches a bus output.
    assign miss_ready_o    = (state_q == IDLE);
    assign command_valid_o = (state_q == LD_REQ) || (state_q == WB_REQ);
    assign command_store_o = (state_q == WB_REQ);
    assign command_addr_o  = (state_q == WB_REQ) ? victimAddr_q : lineAddr_q;
    assign data_in_o       = victimData_q;
    assign command_ready_o = (state_q == LD_WAIT);
    assign fill_valid_o    = (state_q == FILL);
    assign fill_addr_o     = lineAddr_q;
    assign fill_data_o     = fillData_q;
    assign miss_count_o    = missCount_q;
    assign wb_count_o      = wbCount_q;

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Self-checking bench for cache_miss_sequencer: the bench plays both the cache and
// the bus arbiter and predicts every cycle from line-level transaction rules.
module tb_cache_miss_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         missValid;
    logic         missReady;
    logic [63:0]  missAddr;
    logic         missDirty;
    logic [63:0]  victimAddr;
    logic [511:0] victimData;
    logic         fillValid;
    logic [63:0]  fillAddr;
    logic [511:0] fillData;
    logic         commandValid;
    logic         commandStore;
    logic [63:0]  commandAddr;
    logic [511:0] dataIn;
    logic         busReady;
    logic         busValid;
    logic [511:0] dataOut;
    logic         commandReady;
    logic [31:0]  missCount;
    logic [31:0]  wbCount;

    int checks = 0;
    int errors = 0;
    int unsigned modelMissCount = 0;
    int unsigned modelWbCount = 0;

    cache_miss_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .miss_valid_i   (missValid),
        .miss_ready_o   (missReady),
        .miss_addr_i    (missAddr),
        .miss_dirty_i   (missDirty),
        .victim_addr_i  (victimAddr),
        .victim_data_i  (victimData),
        .fill_valid_o   (fillValid),
        .fill_addr_o    (fillAddr),
        .fill_data_o    (fillData),
        .command_valid_o(commandValid),
        .command_store_o(commandStore),
        .command_addr_o (commandAddr),
        .data_in_o      (dataIn),
        .bus_ready_i    (busReady),
        .bus_valid_i    (busValid),
        .data_out_i     (dataOut),
        .command_ready_o(commandReady),
        .miss_count_o   (missCount),
        .wb_count_o     (wbCount)
    );

    always #5 clk = ~clk;

    // A line is 64 bytes; its address is the byte address rounded down to a multiple of 64.
    function automatic logic [63:0] lineOf(input logic [63:0] a);
        return a - (a % 64);
    endfunction

    function automatic logic [511:0] randLine();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] randAddr();
        return {$urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleCheck();
        @(negedge clk);
        checkOutput("idle_miss_ready", 512'(missReady), 512'(1));
        checkOutput("idle_cmd_valid", 512'(commandValid), 512'(0));
        checkOutput("idle_fill_valid", 512'(fillValid), 512'(0));
        checkOutput("idle_miss_count", 512'(missCount), 512'(modelMissCount));
        checkOutput("idle_wb_count", 512'(wbCount), 512'(modelWbCount));
        missValid = 1'b0;
        busReady  = 1'b0;
        busValid  = 1'b0;
    endtask

    // One complete miss transaction, cycle by cycle, with the arbiter delays given.
    task automatic applyStimulus(input logic [63:0] addr, input logic dirty, input logic [63:0] vAddr,
                                 input logic [511:0] vData, input logic [511:0] resp, input int rdyDelay,
                                 input int validDelay, input int wbDelay, input bit spurious, input bit holdValid);
        @(negedge clk);
        checkOutput("start_miss_ready", 512'(missReady), 512'(1));
        checkOutput("start_cmd_valid", 512'(commandValid), 512'(0));
        checkOutput("start_miss_count", 512'(missCount), 512'(modelMissCount));
        checkOutput("start_wb_count", 512'(wbCount), 512'(modelWbCount));
        missValid  = 1'b1;
        missAddr   = addr;
        missDirty  = dirty;
        victimAddr = vAddr;
        victimData = vData;
        busReady   = 1'b0;
        busValid   = 1'b0;
        modelMissCount++;

        for (int k = 0; k <= rdyDelay; k++) begin
            @(negedge clk);
            missValid  = holdValid;
            missAddr   = randAddr();
            victimAddr = randAddr();
            victimData = randLine();
            checkOutput("ld_cmd_valid", 512'(commandValid), 512'(1));
            checkOutput("ld_cmd_store", 512'(commandStore), 512'(0));
            checkOutput("ld_cmd_addr", 512'(commandAddr), 512'(lineOf(addr)));
            checkOutput("ld_miss_ready", 512'(missReady), 512'(0));
            checkOutput("ld_cmd_ready", 512'(commandReady), 512'(0));
            checkOutput("ld_fill_valid", 512'(fillValid), 512'(0));
            checkOutput("ld_miss_count", 512'(missCount), 512'(modelMissCount));
            busReady = (k == rdyDelay);
            busValid = spurious;
            dataOut  = randLine();
        end

        for (int k = 0; k <= validDelay; k++) begin
            @(negedge clk);
            checkOutput("lw_cmd_valid", 512'(commandValid), 512'(0));
            checkOutput("lw_cmd_ready", 512'(commandReady), 512'(1));
            checkOutput("lw_fill_valid", 512'(fillValid), 512'(0));
            checkOutput("lw_miss_ready", 512'(missReady), 512'(0));
            busReady = 1'b0;
            busValid = (k == validDelay);
            dataOut  = (k == validDelay) ? resp : randLine();
        end

        @(negedge clk);
        busValid = 1'b0;
        dataOut  = randLine();
        checkOutput("fill_valid", 512'(fillValid), 512'(1));
        checkOutput("fill_addr", 512'(fillAddr), 512'(lineOf(addr)));
        checkOutput("fill_data", fillData, resp);
        checkOutput("fill_cmd_valid", 512'(commandValid), 512'(0));
        checkOutput("fill_cmd_ready", 512'(commandReady), 512'(0));
        checkOutput("fill_miss_ready", 512'(missReady), 512'(0));

        if (dirty) begin
            for (int k = 0; k <= wbDelay; k++) begin
                @(negedge clk);
                checkOutput("wb_cmd_valid", 512'(commandValid), 512'(1));
                checkOutput("wb_cmd_store", 512'(commandStore), 512'(1));
                checkOutput("wb_cmd_addr", 512'(commandAddr), 512'(lineOf(vAddr)));
                checkOutput("wb_data_in", dataIn, vData);
                checkOutput("wb_miss_ready", 512'(missReady), 512'(0));
                checkOutput("wb_fill_valid", 512'(fillValid), 512'(0));
                checkOutput("wb_wb_count", 512'(wbCount), 512'(modelWbCount));
                busReady = (k == wbDelay);
            end
            modelWbCount++;
        end
    endtask

    // Drive a dirty miss into LD_WAIT (phase 0) or WB_REQ (phase 1), then pulse reset.
    task automatic resetMidFlight(input int phase);
        @(negedge clk);
        checkOutput("rst_pre_miss_ready", 512'(missReady), 512'(1));
        missValid  = 1'b1;
        missAddr   = randAddr();
        missDirty  = 1'b1;
        victimAddr = randAddr();
        victimData = randLine();
        @(negedge clk);
        missValid = 1'b0;
        busReady  = 1'b1;
        @(negedge clk);
        busReady = 1'b0;
        if (phase == 0) begin
            checkOutput("rst_in_ld_wait", 512'(commandReady), 512'(1));
            reset = 1'b1;
        end else begin
            busValid = 1'b1;
            dataOut  = randLine();
            @(negedge clk);
            busValid = 1'b0;
            @(negedge clk);
            checkOutput("rst_in_wb_req", 512'(commandStore), 512'(1));
            reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        modelMissCount = 0;
        modelWbCount   = 0;
        checkOutput("rst_cmd_valid", 512'(commandValid), 512'(0));
        checkOutput("rst_miss_ready", 512'(missReady), 512'(1));
        checkOutput("rst_miss_count", 512'(missCount), 512'(0));
        checkOutput("rst_wb_count", 512'(wbCount), 512'(0));
        checkOutput("rst_fill_valid", 512'(fillValid), 512'(0));
        for (int k = 0; k < 4; k++) begin
            busValid = 1'b1;
            busReady = 1'b1;
            dataOut  = randLine();
            @(negedge clk);
            checkOutput("post_rst_fill_valid", 512'(fillValid), 512'(0));
            checkOutput("post_rst_cmd_valid", 512'(commandValid), 512'(0));
        end
        busValid = 1'b0;
        busReady = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        logic        d;

        reset      = 1'b1;
        missValid  = 1'b0;
        missAddr   = '0;
        missDirty  = 1'b0;
        victimAddr = '0;
        victimData = '0;
        busReady   = 1'b0;
        busValid   = 1'b0;
        dataOut    = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_fill_valid", 512'(fillValid), 512'(0));
        checkOutput("reset_cmd_valid", 512'(commandValid), 512'(0));
        checkOutput("reset_cmd_ready", 512'(commandReady), 512'(0));
        checkOutput("reset_cmd_addr", 512'(commandAddr), 512'(0));
        checkOutput("reset_data_in", dataIn, 512'(0));
        checkOutput("reset_fill_addr", 512'(fillAddr), 512'(0));
        checkOutput("reset_fill_data", fillData, 512'(0));
        checkOutput("reset_miss_count", 512'(missCount), 512'(0));
        checkOutput("reset_wb_count", 512'(wbCount), 512'(0));
        reset = 1'b0;

        $display("[TB] clean miss, ideal arbiter");
        applyStimulus(64'h1000_0047, 1'b0, 64'h0, '0, {64{8'hA5}}, 0, 0, 0, 1'b0, 1'b0);
        idleCheck();

        $display("[TB] dirty miss with writeback");
        applyStimulus(64'h2000_0000, 1'b1, 64'h3000_0010, {64{8'h55}}, randLine(), 0, 0, 0, 1'b0, 1'b0);
        idleCheck();

        $display("[TB] back-pressure on load and store");
        applyStimulus(randAddr(), 1'b1, randAddr(), randLine(), randLine(), 10, 0, 7, 1'b0, 1'b0);
        idleCheck();

        $display("[TB] spurious bus_valid before load acceptance");
        applyStimulus(randAddr(), 1'b0, randAddr(), randLine(), randLine(), 3, 2, 0, 1'b1, 1'b0);
        idleCheck();

        $display("[TB] victim and miss on the same line");
        applyStimulus(64'h4000_0080, 1'b1, 64'h4000_00BF, randLine(), randLine(), 1, 1, 1, 1'b0, 1'b0);
        idleCheck();

        $display("[TB] reset in LD_WAIT and in WB_REQ");
        resetMidFlight(0);
        idleCheck();
        resetMidFlight(1);
        idleCheck();

        $display("[TB] four back-to-back dirty misses");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(randAddr(), 1'b1, randAddr(), randLine(), randLine(), 0, 0, 0, 1'b0, 1'b1);
        end
        idleCheck();
        checkOutput("b2b_miss_count", 512'(missCount), 512'(4));
        checkOutput("b2b_wb_count", 512'(wbCount), 512'(4));

        $display("[TB] randomized misses");
        for (int i = 0; i < 24; i++) begin
            a = randAddr();
            d = 1'($urandom_range(0, 1));
            applyStimulus(a, d, randAddr(), randLine(), randLine(), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idleCheck();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
